pwm_fader_multi: RTL



---
 rtl/pwm_fader_multi.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pwm_fader_multi.sv
// Multi-channel PWM LED fader: each channel runs off/static/breathe/blink up to its own
// brightness ceiling; active duty is latched only at PWM period boundaries.
module pwm_fader_multi #(
    parameter int unsigned N_CH      = 8,
    parameter int unsigned DUTY_W    = 8,
    parameter int unsigned PRESCALE  = 78,
    parameter int unsigned FADE_TICK = 3_125_000,
    parameter int unsigned STEP      = 4,
    parameter int unsigned BLINK_DIV = 4,
    localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [DUTY_W-1:0] cfg_level,
    output logic [N_CH-1:0]   leds,
    output logic              period_start
);

    localparam int unsigned PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned FADE_W = $clog2(FADE_TICK);
    localparam int unsigned BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_TICK - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_DIV - 1);
    localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W + 1)'(STEP);

    typedef enum logic [1:0] {
        ModeOff     = 2'd0,
        ModeStatic  = 2'd1,
        ModeBreathe = 2'd2,
        ModeBlink   = 2'd3
    } mode_e;

    // Shared timebase
    logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [FADE_W-1:0] fade_cnt_q, fade_cnt_d;
    logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic              pre_wrap;
    logic              b_evt;
    logic              f_evt;

    // Per-channel state
    mode_e             mode_q  [N_CH];
    mode_e             mode_d  [N_CH];
    logic [DUTY_W-1:0] level_q [N_CH];
    logic [DUTY_W-1:0] level_d [N_CH];
    logic [DUTY_W-1:0] cur_q   [N_CH];
    logic [DUTY_W-1:0] cur_d   [N_CH];
    logic [DUTY_W-1:0] act_q   [N_CH];
    logic [DUTY_W-1:0] act_d   [N_CH];
    logic [N_CH-1:0]   dir_q, dir_d;
    logic [N_CH-1:0]   leds_d;
    logic              wr_ok;

    assign wr_ok = cfg_we && ({1'b0, cfg_ch} < (CH_W + 1)'(N_CH));

    always_comb begin
        pre_wrap      = (pre_cnt_q == PRE_LAST);
        pre_cnt_d     = pre_wrap ? '0 : pre_cnt_q + 1'b1;
        // pwm_cnt spans the full DUTY_W range, so it wraps naturally
        pwm_cnt_d     = pre_wrap ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        b_evt         = pre_wrap && (pwm_cnt_q == '1);
        f_evt         = (fade_cnt_q == FADE_LAST);
        fade_cnt_d    = f_evt ? '0 : fade_cnt_q + 1'b1;
        blk_cnt_d     = blk_cnt_q;
        blink_phase_d = blink_phase_q;
        if (f_evt) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d     = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        dir_d  = dir_q;
        leds_d = '0;
        for (int k = 0; k < N_CH; k++) begin
            mode_d[k]  = mode_q[k];
            level_d[k] = level_q[k];
            cur_d[k]   = cur_q[k];
            act_d[k]   = b_evt ? cur_q[k] : act_q[k];
            leds_d[k]  = (pwm_cnt_q < act_q[k]);

            // A write to this channel takes priority over a coincident fade tick
            if (wr_ok && (cfg_ch == CH_W'(k))) begin
                mode_d[k]  = mode_e'(cfg_mode);
                level_d[k] = cfg_level;
                if (mode_e'(cfg_mode) == ModeBreathe) begin
                    cur_d[k] = '0;
                    dir_d[k] = 1'b0;
                end
            end else begin
                unique case (mode_q[k])
                    ModeOff:    cur_d[k] = '0;
                    ModeStatic: cur_d[k] = level_q[k];
                    ModeBlink: begin
                        if (f_evt) begin
                            cur_d[k] = blink_phase_q ? level_q[k] : '0;
                        end
                    end
                    ModeBreathe: begin
                        if (f_evt) begin
                            if (!dir_q[k]) begin
                                if (({1'b0, cur_q[k]} + STEP_X) >= {1'b0, level_q[k]}) begin
                                    cur_d[k] = level_q[k];
                                    dir_d[k] = 1'b1;
                                end else begin
                                    cur_d[k] = cur_q[k] + STEP_X[DUTY_W-1:0];
                                end
                            end else begin
                                if ({1'b0, cur_q[k]} <= STEP_X) begin
                                    cur_d[k] = '0;
                                    dir_d[k] = 1'b0;
                                end else begin
                                    cur_d[k] = cur_q[k] - STEP_X[DUTY_W-1:0];
                                end
                            end
                        end
                    end
                    default: cur_d[k] = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q     <= '0;
            pwm_cnt_q     <= '0;
            fade_cnt_q    <= '0;
            blk_cnt_q     <= '0;
            blink_phase_q <= 1'b0;
            dir_q         <= '0;
            leds          <= '0;
            period_start  <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                mode_q[k]  <= ModeOff;
                level_q[k] <= '0;
                cur_q[k]   <= '0;
                act_q[k]   <= '0;
            end
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            fade_cnt_q    <= fade_cnt_d;
            blk_cnt_q     <= blk_cnt_d;
            blink_phase_q <= blink_phase_d;
            dir_q         <= dir_d;
            leds          <= leds_d;
            period_start  <= b_evt;
            for (int k = 0; k < N_CH; k++) begin
                mode_q[k]  <= mode_d[k];
                level_q[k] <= level_d[k];
                cur_q[k]   <= cur_d[k];
                act_q[k]   <= act_d[k];
            end
        end
    end

endmodule
